// File: rtl/if_prefetch_unit_pkg.sv
// Shared definitions for the instruction-fetch front end.
//   INSTR_BYTES : PC increment per fetched instruction
//   NOP_INSTR   : addi x0,x0,0, presented when no instruction is valid
//   cnt_width() : bits needed to hold a count in 0..depth
package if_prefetch_unit_pkg;

  localparam int INSTR_BYTES = 4;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/if_prefetch_unit_if.sv
// Instruction-memory request/response bus.
//   master : fetch unit side (drives imem_req/imem_addr)
//   slave  : memory side (drives imem_ready/imem_rvalid/imem_rdata)
// A request is accepted when imem_req & imem_ready; responses return in
// request order on imem_rvalid/imem_rdata.
interface if_prefetch_unit_if #(
  parameter int ADDR_SIZE = 10,
  parameter int WORD_SIZE = 32
);
  logic                 imem_req;
  logic [ADDR_SIZE-1:0] imem_addr;
  logic                 imem_ready;
  logic                 imem_rvalid;
  logic [WORD_SIZE-1:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ready, imem_rvalid, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ready, imem_rvalid, imem_rdata);
endinterface

// File: rtl/if_prefetch_unit_chk.sv
// Run-time checks on the fetch unit's bookkeeping.
//   push/full           : queue must never be written while full
//   outstanding/drop_cnt: drop_cnt <= outstanding <= DEPTH
module if_prefetch_unit_chk #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input logic          clk,
  input logic          rst,
  input logic          push,
  input logic          full,
  input logic [CW-1:0] outstanding,
  input logic [CW-1:0] drop_cnt
);
  // Counter and queue invariants, evaluated every cycle outside reset.
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(push && full)) else $fatal(1, "prefetch queue written while full");
      assert (drop_cnt <= outstanding) else $error("drop count exceeds outstanding requests");
      assert (outstanding <= CW'(DEPTH)) else $error("outstanding requests exceed depth");
    end
  end
endmodule

// File: rtl/if_prefetch_unit_sync_fifo.sv
// Synchronous FIFO holding fetched {pc, instruction} entries.
//   clk, rst     : clock, synchronous active-high reset
//   flush        : synchronous clear (takes priority over push/pop)
//   push, din    : write an entry (ignored when full)
//   pop          : drop the head (ignored when empty)
//   dout         : head entry, read straight from storage flops
//   full, empty, count : occupancy
module sync_fifo
  import if_prefetch_unit_pkg::*;
#(
  parameter int WIDTH = 42,
  parameter int DEPTH = 4,
  parameter int CW    = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  // Qualify requests against occupancy and expose the head and status.
  always_comb begin
    push_ok_s = push && (count_r != CW'(DEPTH));
    pop_ok_s  = pop && (count_r != {CW{1'b0}});
    dout      = mem_r[rd_ptr_r];
    full      = (count_r == CW'(DEPTH));
    empty     = (count_r == {CW{1'b0}});
    count     = count_r;
  end

  // Pointers and occupancy; flush empties the queue without touching storage.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1'b1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1'b1);
      end
      count_r <= count_r + CW'(push_ok_s) - CW'(pop_ok_s);
    end
  end

  // Entry storage; needs no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (push_ok_s && !flush && !rst) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

endmodule

// File: rtl/if_prefetch_unit.sv
// Instruction-fetch front end: PC generator, in-order variable-latency imem
// interface and a DEPTH-entry prefetch queue feeding IF/ID.
//   clk, rst        : clock, synchronous active-high reset
//   imem            : request/response bus (master side)
//   redirect, redirect_target : taken branch/jump; flush and refetch
//   instr_valid, instr, instr_pc : queue head (NOP / 0 when invalid)
//   instr_ready     : downstream consumes the head
module if_prefetch_unit
  import if_prefetch_unit_pkg::*;
#(
  parameter int          WORD_SIZE = 32,
  parameter int          ADDR_SIZE = 10,
  parameter int          DEPTH     = 4,
  parameter int unsigned RESET_PC  = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  if_prefetch_unit_if.master   imem,
  input  logic                 redirect,
  input  logic [ADDR_SIZE-1:0] redirect_target,
  output logic                 instr_valid,
  output logic [WORD_SIZE-1:0] instr,
  output logic [ADDR_SIZE-1:0] instr_pc,
  input  logic                 instr_ready
);
  localparam int CW = cnt_width(DEPTH);
  localparam int EW = ADDR_SIZE + WORD_SIZE;
  localparam logic [ADDR_SIZE-1:0] PC_STEP = ADDR_SIZE'(INSTR_BYTES);

  logic [ADDR_SIZE-1:0] fetch_pc_r;
  logic [ADDR_SIZE-1:0] resp_pc_r;
  logic [CW-1:0]        outstanding_r;
  logic [CW-1:0]        drop_cnt_r;
  logic [ADDR_SIZE-1:0] target_s;
  logic [CW:0]          inflight_s;
  logic [CW-1:0]        count_s;
  logic [EW-1:0]        head_s;
  logic                 issue_s, hs_s, rsp_s, keep_s, push_s, pop_s;
  logic                 full_s, empty_s;

  // Issue decision, response routing and head presentation.
  always_comb begin
    target_s = {redirect_target[ADDR_SIZE-1:2], 2'b00};
    // Entries queued plus live (non-dropped) requests must leave room for one more.
    inflight_s = {1'b0, count_s} + {1'b0, outstanding_r} - {1'b0, drop_cnt_r};
    issue_s = !rst && !redirect && (outstanding_r < CW'(DEPTH))
              && (inflight_s < (CW+1)'(DEPTH));
    hs_s   = issue_s && imem.imem_ready;
    rsp_s  = imem.imem_rvalid && !rst;
    keep_s = rsp_s && (drop_cnt_r == {CW{1'b0}});
    push_s = keep_s && !redirect;
    instr_valid = !rst && !empty_s;
    pop_s = instr_valid && instr_ready && !redirect;
    if (instr_valid) begin
      instr    = head_s[WORD_SIZE-1:0];
      instr_pc = head_s[EW-1:WORD_SIZE];
    end else begin
      instr    = WORD_SIZE'(NOP_INSTR);
      instr_pc = {ADDR_SIZE{1'b0}};
    end
    imem.imem_req  = issue_s;
    imem.imem_addr = fetch_pc_r;
  end

  // PC generators and request/drop bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_r    <= ADDR_SIZE'(RESET_PC);
      resp_pc_r     <= ADDR_SIZE'(RESET_PC);
      outstanding_r <= {CW{1'b0}};
      drop_cnt_r    <= {CW{1'b0}};
    end else if (redirect) begin
      fetch_pc_r    <= target_s;
      resp_pc_r     <= target_s;
      outstanding_r <= outstanding_r - CW'(rsp_s);
      // Every request still unreturned after this cycle belongs to the old path.
      drop_cnt_r    <= outstanding_r - CW'(rsp_s);
    end else begin
      if (hs_s) begin
        fetch_pc_r <= fetch_pc_r + PC_STEP;
      end
      if (push_s) begin
        resp_pc_r <= resp_pc_r + PC_STEP;
      end
      if (rsp_s && !keep_s) begin
        drop_cnt_r <= drop_cnt_r - CW'(1'b1);
      end
      outstanding_r <= outstanding_r + CW'(hs_s) - CW'(rsp_s);
    end
  end

  sync_fifo #(.WIDTH(EW), .DEPTH(DEPTH), .CW(CW)) u_queue (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect),
    .push  (push_s),
    .pop   (pop_s),
    .din   ({resp_pc_r, imem.imem_rdata}),
    .dout  (head_s),
    .full  (full_s),
    .empty (empty_s),
    .count (count_s)
  );

  if_prefetch_unit_chk #(.DEPTH(DEPTH), .CW(CW)) u_chk (
    .clk         (clk),
    .rst         (rst),
    .push        (push_s),
    .full        (full_s),
    .outstanding (outstanding_r),
    .drop_cnt    (drop_cnt_r)
  );

endmodule

// File: tb/tb_if_prefetch_unit.sv
`timescale 1ns/1ps
module tb_if_prefetch_unit;
  localparam int WS = 32;
  localparam int AS = 10;
  localparam int DEPTH = 4;
  localparam logic [AS-1:0] RST_PC = 10'h000;
  localparam logic [WS-1:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic redirect = 1'b0;
  logic [AS-1:0] redirect_target = 10'h000;
  logic instr_ready = 1'b0;
  logic instr_valid;
  logic [WS-1:0] instr;
  logic [AS-1:0] instr_pc;

  if_prefetch_unit_if #(.ADDR_SIZE(AS), .WORD_SIZE(WS)) bus ();

  if_prefetch_unit #(.WORD_SIZE(WS), .ADDR_SIZE(AS), .DEPTH(DEPTH), .RESET_PC(0)) dut (
    .clk(clk), .rst(rst), .imem(bus), .redirect(redirect), .redirect_target(redirect_target),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready)
  );

  always #5 clk = ~clk;

  // Memory environment: every accepted request, tagged with the program path it belongs to.
  typedef struct { logic [AS-1:0] addr; int due; int epoch; } req_t;
  req_t memq[$];

  // Reference model: path epoch, valid entries waiting in the queue, program-order PCs.
  int cur_epoch = 0, held = 0, cyc = 0;
  logic [AS-1:0] exp_pc = RST_PC, next_req_pc = RST_PC;
  int lat_min = 1, lat_max = 1, p_ready = 100, p_rvalid = 100;
  int checks = 0, failures = 0, n_hs = 0, n_pops = 0, first_valid_cyc = -1;
  logic last_rv = 1'b0, last_valid = 1'b0, last_req = 1'b0;
  logic [AS-1:0] pop_pc[$];
  int pop_cyc[$];
  logic [AS-1:0] hs_addr[$];

  function automatic logic [WS-1:0] prog(input logic [AS-1:0] a);
    return {6'h15, a, ~a, 6'h2a};
  endfunction

  task automatic clear_logs();
    pop_pc.delete(); pop_cyc.delete(); hs_addr.delete();
    n_hs = 0; n_pops = 0; first_valid_cyc = -1;
  endtask

  // One clock cycle: drive memory side, compare DUT against the model, advance both.
  task automatic step();
    int live;
    bit exp_req, exp_valid, pop_m;
    req_t ent, nr;
    bus.imem_ready = ($urandom_range(99) < p_ready);
    if (!rst && memq.size() > 0 && memq[0].due <= cyc && $urandom_range(99) < p_rvalid) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata = prog(memq[0].addr);
    end else begin
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata = $urandom;
    end
    @(negedge clk);
    live = 0;
    foreach (memq[i]) if (memq[i].epoch == cur_epoch) live++;
    last_rv = bus.imem_rvalid; last_valid = instr_valid; last_req = bus.imem_req;
    if (rst) begin
      checks += 4;
      if (bus.imem_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%0b exp=0 cyc=%0d", bus.imem_req, cyc); end
      if (instr_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0b exp=0 cyc=%0d", instr_valid, cyc); end
      if (instr !== NOP) begin failures++; $display("FAIL rst_instr got=%0h exp=%0h", instr, NOP); end
      if (instr_pc !== 10'h000) begin failures++; $display("FAIL rst_pc got=%0h exp=0", instr_pc); end
      memq.delete(); held = 0; cur_epoch++; exp_pc = RST_PC; next_req_pc = RST_PC;
    end else begin
      exp_req = !redirect && (memq.size() < DEPTH) && (held + live < DEPTH);
      exp_valid = (held > 0);
      checks++;
      if (bus.imem_req !== exp_req) begin failures++; $display("FAIL imem_req got=%0b exp=%0b cyc=%0d", bus.imem_req, exp_req, cyc); end
      if (exp_req) begin
        checks++;
        if (bus.imem_addr !== next_req_pc) begin failures++; $display("FAIL imem_addr got=%0h exp=%0h cyc=%0d", bus.imem_addr, next_req_pc, cyc); end
      end
      checks++;
      if (instr_valid !== exp_valid) begin failures++; $display("FAIL instr_valid got=%0b exp=%0b cyc=%0d", instr_valid, exp_valid, cyc); end
      checks += 2;
      if (exp_valid) begin
        if (instr_pc !== exp_pc) begin failures++; $display("FAIL instr_pc got=%0h exp=%0h cyc=%0d", instr_pc, exp_pc, cyc); end
        if (instr !== prog(exp_pc)) begin failures++; $display("FAIL instr got=%0h exp=%0h cyc=%0d", instr, prog(exp_pc), cyc); end
      end else begin
        if (instr_pc !== 10'h000) begin failures++; $display("FAIL idle_pc got=%0h exp=0 cyc=%0d", instr_pc, cyc); end
        if (instr !== NOP) begin failures++; $display("FAIL idle_instr got=%0h exp=%0h cyc=%0d", instr, NOP, cyc); end
      end
      checks += 2;
      if (int'(dut.outstanding_r) != memq.size()) begin failures++; $display("FAIL outstanding got=%0d exp=%0d cyc=%0d", dut.outstanding_r, memq.size(), cyc); end
      if (int'(dut.drop_cnt_r) != memq.size() - live) begin failures++; $display("FAIL drop_cnt got=%0d exp=%0d cyc=%0d", dut.drop_cnt_r, memq.size() - live, cyc); end
      if (instr_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (instr_valid && instr_ready && !redirect) begin
        n_pops++; pop_pc.push_back(instr_pc); pop_cyc.push_back(cyc);
      end
      pop_m = exp_valid && instr_ready && !redirect;
      if (bus.imem_rvalid) begin
        ent = memq.pop_front();
        if (ent.epoch == cur_epoch && !redirect) held++;
      end
      if (pop_m) begin held--; exp_pc = exp_pc + 10'd4; end
      if (bus.imem_req && bus.imem_ready) begin
        n_hs++; hs_addr.push_back(bus.imem_addr);
        nr.addr = bus.imem_addr;
        nr.due = cyc + int'($urandom_range(lat_max, lat_min));
        nr.epoch = cur_epoch;
        memq.push_back(nr);
      end
      if (exp_req && bus.imem_ready) next_req_pc = next_req_pc + 10'd4;
      if (redirect) begin
        held = 0; cur_epoch++;
        exp_pc = {redirect_target[AS-1:2], 2'b00};
        next_req_pc = {redirect_target[AS-1:2], 2'b00};
      end
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1; redirect = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic set_mem(input int lmin, input int lmax, input int pr, input int pv);
    lat_min = lmin; lat_max = lmax; p_ready = pr; p_rvalid = pv;
  endtask

  task automatic test_reset();
    set_mem(1, 1, 100, 100); instr_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 6; i++) step();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin instr_ready = $urandom_range(1); step(); end
    rst = 1'b0; instr_ready = 1'b1;
    clear_logs();
    for (int i = 0; i < 6; i++) step();
    checks++;
    if (hs_addr.size() == 0 || hs_addr[0] !== RST_PC) begin failures++; $display("FAIL reset_first_addr got_n=%0d exp_addr=0", hs_addr.size()); end
  endtask

  task automatic test_stream();
    int start;
    set_mem(1, 1, 100, 100); instr_ready = 1'b1;
    do_reset(); clear_logs(); start = cyc;
    for (int i = 0; i < 20; i++) step();
    checks += 2;
    if (first_valid_cyc - start != 2) begin failures++; $display("FAIL first_valid got=%0d exp=2", first_valid_cyc - start); end
    if (n_pops != 18) begin failures++; $display("FAIL stream_pops got=%0d exp=18", n_pops); end
  endtask

  task automatic test_stall();
    int rel;
    set_mem(1, 1, 100, 100); instr_ready = 1'b0;
    do_reset(); clear_logs();
    for (int i = 0; i < 10; i++) step();
    checks += 2;
    if (n_hs != 4) begin failures++; $display("FAIL stall_reqs got=%0d exp=4", n_hs); end
    if (last_req !== 1'b0) begin failures++; $display("FAIL stall_req_low got=%0b exp=0", last_req); end
    clear_logs(); rel = cyc; instr_ready = 1'b1;
    for (int i = 0; i < 8; i++) step();
    checks++;
    if (pop_pc.size() < 4) begin failures++; $display("FAIL drain_count got=%0d exp>=4", pop_pc.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        checks += 2;
        if (pop_pc[i] !== AS'(4 * i)) begin failures++; $display("FAIL drain_pc got=%0h exp=%0h", pop_pc[i], 4 * i); end
        if (pop_cyc[i] != rel + i) begin failures++; $display("FAIL drain_cyc got=%0d exp=%0d", pop_cyc[i] - rel, i); end
      end
    end
    checks++;
    if (hs_addr.size() == 0 || hs_addr[0] !== 10'h010) begin failures++; $display("FAIL resume_addr got_n=%0d exp_addr=10", hs_addr.size()); end
  endtask

  task automatic test_redirect_drop();
    set_mem(3, 3, 100, 100); instr_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 3; i++) step();
    p_rvalid = 0; redirect = 1'b1; redirect_target = 10'h106;
    step();
    redirect = 1'b0; p_rvalid = 100;
    checks++;
    if (int'(dut.drop_cnt_r) != 3) begin failures++; $display("FAIL drop_after_redirect got=%0d exp=3", dut.drop_cnt_r); end
    clear_logs();
    for (int i = 0; i < 12; i++) step();
    checks++;
    if (pop_pc.size() == 0 || pop_pc[0] !== 10'h104) begin failures++; $display("FAIL redirect_target_pc got_n=%0d exp_pc=104", pop_pc.size()); end
  endtask

  task automatic test_redirect_rvalid_pop();
    set_mem(2, 2, 100, 100); instr_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 6; i++) step();
    redirect = 1'b1; redirect_target = 10'h200;
    step();
    redirect = 1'b0;
    checks += 4;
    if (last_rv !== 1'b1) begin failures++; $display("FAIL same_cycle_rvalid got=%0b exp=1", last_rv); end
    if (last_valid !== 1'b1) begin failures++; $display("FAIL same_cycle_valid got=%0b exp=1", last_valid); end
    if (int'(dut.drop_cnt_r) != 1) begin failures++; $display("FAIL rv_redirect_drop got=%0d exp=1", dut.drop_cnt_r); end
    if (int'(dut.outstanding_r) != 1) begin failures++; $display("FAIL rv_redirect_outst got=%0d exp=1", dut.outstanding_r); end
    clear_logs();
    step();
    checks++;
    if (last_valid !== 1'b0) begin failures++; $display("FAIL post_redirect_valid got=%0b exp=0", last_valid); end
    for (int i = 0; i < 10; i++) step();
    checks++;
    if (pop_pc.size() == 0 || pop_pc[0] !== 10'h200) begin failures++; $display("FAIL rv_redirect_pc got_n=%0d exp_pc=200", pop_pc.size()); end
  endtask

  task automatic test_wrap();
    logic [AS-1:0] wexp [4];
    wexp[0] = 10'h3F8; wexp[1] = 10'h3FC; wexp[2] = 10'h000; wexp[3] = 10'h004;
    set_mem(1, 1, 100, 100); instr_ready = 1'b1;
    do_reset();
    step(); step();
    redirect = 1'b1; redirect_target = 10'h3F8;
    step();
    redirect = 1'b0;
    clear_logs();
    for (int i = 0; i < 10; i++) step();
    checks++;
    if (hs_addr.size() < 4 || pop_pc.size() < 4) begin failures++; $display("FAIL wrap_count got_hs=%0d got_pop=%0d exp>=4", hs_addr.size(), pop_pc.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        checks += 2;
        if (hs_addr[i] !== wexp[i]) begin failures++; $display("FAIL wrap_addr got=%0h exp=%0h", hs_addr[i], wexp[i]); end
        if (pop_pc[i] !== wexp[i]) begin failures++; $display("FAIL wrap_pc got=%0h exp=%0h", pop_pc[i], wexp[i]); end
      end
    end
  endtask

  task automatic test_random();
    set_mem(1, 4, 70, 70);
    do_reset(); clear_logs();
    for (int i = 0; i < 10000; i++) begin
      rst = ($urandom_range(999) == 0);
      redirect = !rst && ($urandom_range(99) < 3);
      redirect_target = AS'($urandom);
      instr_ready = ($urandom_range(99) < 60);
      step();
    end
    rst = 1'b0; redirect = 1'b0;
    checks++;
    if (n_pops < 1000) begin failures++; $display("FAIL random_progress got=%0d exp>=1000", n_pops); end
  endtask

  initial begin
    bus.imem_ready = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'h0000_0000;
    @(posedge clk); #1;
    test_reset();
    test_stream();
    test_stall();
    test_redirect_drop();
    test_redirect_rvalid_pop();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
